dm_store_mem: RTL and testbench

- Data memory for the MEM stage of the 5-stage MIPS pipeline.
- Performs aligned byte, halfword and word stores with per-byte write enables.
- Reads the full 32-bit word at the requested address and registers it, with the byte offset and load type, into the MEM/WB boundary.
- The W-stage load-extension logic consumes those registered outputs to select and extend the loaded byte or halfword.
- Detects misaligned and out-of-range accesses and suppresses the offending store.

---
 rtl/dm_store_mem_pkg.sv | 25 ++
 rtl/dm_store_align.sv | 66 ++++++
 rtl/dm_store_mem.sv | 133 +++++++++++++
 tb/tb_dm_store_mem.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dm_store_mem_pkg.sv
// ---------------------------------------------------------------------------
// dm_store_mem_pkg
// Shared constants for the MEM-stage data memory and its store aligner.
// The load encodings match those decoded by the W-stage load extender, so
// load_sel can pass straight through the MEM/WB boundary.
// ---------------------------------------------------------------------------
package dm_store_mem_pkg;

   // Default word-address width: 2^10 words of 32 bits = 4 KB.
   localparam int DM_ADDR_WIDTH = 10;

   // Store type encodings (store_sel).
   localparam logic [1:0] ST_NONE = 2'b00;
   localparam logic [1:0] ST_SW   = 2'b01;
   localparam logic [1:0] ST_SH   = 2'b10;
   localparam logic [1:0] ST_SB   = 2'b11;

   // Load type encodings (load_sel).
   localparam logic [2:0] LD_LW  = 3'b000;
   localparam logic [2:0] LD_LBU = 3'b001;
   localparam logic [2:0] LD_LB  = 3'b010;
   localparam logic [2:0] LD_LHU = 3'b011;
   localparam logic [2:0] LD_LH  = 3'b100;

endpackage

// File: rtl/dm_store_align.sv
// ---------------------------------------------------------------------------
// dm_store_align
// Combinational store aligner. From the store type and byte offset it builds
// the raw per-byte write enables, replicates the store value onto every lane
// it could land in, and flags a misaligned store. The enables returned here
// are not yet qualified by valid/error; the caller does that.
//
// Ports:
//   store_sel  in  2   store type (ST_NONE/ST_SW/ST_SH/ST_SB)
//   byte_off   in  2   addr[1:0]
//   wdata      in  32  store data, value in the low bits
//   be         out 4   raw byte-lane write enables
//   wdata_al   out 32  lane-replicated store data
//   misaligned out 1   store is misaligned for its size
// ---------------------------------------------------------------------------
import dm_store_mem_pkg::*;

module dm_store_align (
   input  logic [1:0]  store_sel,
   input  logic [1:0]  byte_off,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_al,
   output logic        misaligned
);

   // Lane enables, data replication and misalignment per store type.
   always_comb begin
      be         = 4'b0000;
      wdata_al   = wdata;
      misaligned = 1'b0;
      case (store_sel)
         ST_NONE: begin
            be         = 4'b0000;
            wdata_al   = wdata;
            misaligned = 1'b0;
         end
         ST_SW: begin
            be         = 4'b1111;
            wdata_al   = wdata;
            misaligned = (byte_off != 2'b00);
         end
         ST_SH: begin
            // Upper halfword when addr[1] is set; addr[0] must be clear.
            if (byte_off[1]) begin
               be = 4'b1100;
            end else begin
               be = 4'b0011;
            end
            wdata_al   = {wdata[15:0], wdata[15:0]};
            misaligned = byte_off[0];
         end
         ST_SB: begin
            be         = 4'b0001 << byte_off;
            wdata_al   = {4{wdata[7:0]}};
            misaligned = 1'b0;
         end
         default: begin
            be         = 4'b0000;
            wdata_al   = wdata;
            misaligned = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/dm_store_mem.sv
// ---------------------------------------------------------------------------
// dm_store_mem
// MEM-stage data memory of the 5-stage MIPS pipeline. Performs aligned
// byte/halfword/word stores with per-byte enables, reads the full word at
// the requested address, and registers it together with the byte offset,
// load type, valid and access-error flag into the MEM/WB boundary.
// Misaligned or out-of-range accesses suppress the store and raise
// addr_err_w one cycle later.
//
// Ports:
//   clk        in  1   pipeline clock (rising edge)
//   rst_n      in  1   asynchronous active-low reset (clears memory too)
//   m_valid    in  1   MEM-stage instruction valid (0 = bubble)
//   addr       in  32  byte address from the ALU
//   wdata      in  32  store data, value in the low bits
//   store_sel  in  2   store type
//   load_sel   in  3   load type
//   load_en    in  1   MEM-stage instruction is a load
//   rdata_w    out 32  registered word read at addr
//   byte_w     out 2   registered addr[1:0]
//   load_sel_w out 3   registered load_sel
//   valid_w    out 1   registered m_valid
//   addr_err_w out 1   registered access-error flag
// ---------------------------------------------------------------------------
import dm_store_mem_pkg::*;

module dm_store_mem #(
   parameter int ADDR_WIDTH = DM_ADDR_WIDTH
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m_valid,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [1:0]  store_sel,
   input  logic [2:0]  load_sel,
   input  logic        load_en,
   output logic [31:0] rdata_w,
   output logic [1:0]  byte_w,
   output logic [2:0]  load_sel_w,
   output logic        valid_w,
   output logic        addr_err_w
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [31:0]           mem_r [DEPTH];
   logic [ADDR_WIDTH-1:0] idx_s;
   logic                  in_range_s;
   logic [3:0]            be_raw_s;
   logic [3:0]            be_s;
   logic [31:0]           wdata_al_s;
   logic                  st_mis_s;
   logic                  ld_mis_s;
   logic                  mis_s;
   logic                  is_store_s;
   logic                  err_s;
   logic [31:0]           rdata_s;

   assign idx_s      = addr[ADDR_WIDTH+1:2];
   assign in_range_s = (addr[31:ADDR_WIDTH+2] == {(30-ADDR_WIDTH){1'b0}});
   assign is_store_s = (store_sel != ST_NONE);

   dm_store_align u_align (
      .store_sel  (store_sel),
      .byte_off   (addr[1:0]),
      .wdata      (wdata),
      .be         (be_raw_s),
      .wdata_al   (wdata_al_s),
      .misaligned (st_mis_s)
   );

   // Load misalignment: words need offset 0, halfwords an even offset.
   always_comb begin
      ld_mis_s = 1'b0;
      case (load_sel)
         LD_LW:         ld_mis_s = (addr[1:0] != 2'b00);
         LD_LH, LD_LHU: ld_mis_s = addr[0];
         LD_LB, LD_LBU: ld_mis_s = 1'b0;
         default:       ld_mis_s = 1'b0;
      endcase
   end

   // Access error and qualified byte enables; an errored store writes nothing.
   always_comb begin
      mis_s = (is_store_s & st_mis_s) | (load_en & ld_mis_s);
      err_s = m_valid & (is_store_s | load_en) & (mis_s | ~in_range_s);
      if (m_valid && is_store_s && !err_s) begin
         be_s = be_raw_s;
      end else begin
         be_s = 4'b0000;
      end
   end

   // Combinational read; out-of-range addresses read as zero.
   always_comb begin
      if (in_range_s) begin
         rdata_s = mem_r[idx_s];
      end else begin
         rdata_s = 32'h0000_0000;
      end
   end

   // Memory array: async clear, then per-lane byte writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_r <= '{default: 32'h0000_0000};
      end else begin
         if (be_s[0]) mem_r[idx_s][7:0]   <= wdata_al_s[7:0];
         if (be_s[1]) mem_r[idx_s][15:8]  <= wdata_al_s[15:8];
         if (be_s[2]) mem_r[idx_s][23:16] <= wdata_al_s[23:16];
         if (be_s[3]) mem_r[idx_s][31:24] <= wdata_al_s[31:24];
      end
   end

   // MEM/WB boundary registers; rdata_s is the pre-write word on a same-edge store.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_w    <= 32'h0000_0000;
         byte_w     <= 2'b00;
         load_sel_w <= 3'b000;
         valid_w    <= 1'b0;
         addr_err_w <= 1'b0;
      end else begin
         rdata_w    <= rdata_s;
         byte_w     <= addr[1:0];
         load_sel_w <= load_sel;
         valid_w    <= m_valid;
         addr_err_w <= err_s;
      end
   end

endmodule

// File: tb/tb_dm_store_mem.sv
// ---------------------------------------------------------------------------
// tb_dm_store_mem
// Directed testbench for dm_store_mem: reset, word/byte/halfword stores and
// loads, misaligned and out-of-range errors, bubbles, read-before-write and
// reset in the middle of a store sequence.
// ---------------------------------------------------------------------------
module tb_dm_store_mem;

   logic        clk;
   logic        rst_n;
   logic        m_valid;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  store_sel;
   logic [2:0]  load_sel;
   logic        load_en;
   logic [31:0] rdata_w;
   logic [1:0]  byte_w;
   logic [2:0]  load_sel_w;
   logic        valid_w;
   logic        addr_err_w;

   int checks   = 0;
   int failures = 0;

   dm_store_mem #(.ADDR_WIDTH(10)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .m_valid    (m_valid),
      .addr       (addr),
      .wdata      (wdata),
      .store_sel  (store_sel),
      .load_sel   (load_sel),
      .load_en    (load_en),
      .rdata_w    (rdata_w),
      .byte_w     (byte_w),
      .load_sel_w (load_sel_w),
      .valid_w    (valid_w),
      .addr_err_w (addr_err_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Present one MEM-stage instruction, clock it, and settle past the edge.
   task automatic op(input logic v, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] st, input logic le, input logic [2:0] ls);
      m_valid   = v;
      addr      = a;
      wdata     = d;
      store_sel = st;
      load_en   = le;
      load_sel  = ls;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_rdata"},  rdata_w, 32'h0000_0000);
      chk({tag, "_byte"},   {30'd0, byte_w}, 32'd0);
      chk({tag, "_ldsel"},  {29'd0, load_sel_w}, 32'd0);
      chk({tag, "_valid"},  {31'd0, valid_w}, 32'd0);
      chk({tag, "_err"},    {31'd0, addr_err_w}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      m_valid = 1'b0; addr = 32'h0; wdata = 32'h0;
      store_sel = 2'b00; load_sel = 3'b000; load_en = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_reset_outs("rst");
      rst_n = 1'b1;

      // LW of a cleared location.
      op(1'b1, 32'h0000_0010, 32'h0, 2'b00, 1'b1, 3'b000);
      chk("lw0_rdata", rdata_w, 32'h0000_0000);
      chk("lw0_valid", {31'd0, valid_w}, 32'd1);
      chk("lw0_err",   {31'd0, addr_err_w}, 32'd0);

      // SW then LW.
      op(1'b1, 32'h0000_0020, 32'h1234_5678, 2'b01, 1'b0, 3'b000);
      chk("sw_err", {31'd0, addr_err_w}, 32'd0);
      op(1'b1, 32'h0000_0020, 32'h0, 2'b00, 1'b1, 3'b000);
      chk("lw20_rdata", rdata_w, 32'h1234_5678);

      // SB into the top lane, then LB.
      op(1'b1, 32'h0000_0023, 32'h0000_00AB, 2'b11, 1'b0, 3'b000);
      op(1'b1, 32'h0000_0023, 32'h0, 2'b00, 1'b1, 3'b010);
      chk("lb_rdata", rdata_w, 32'hAB34_5678);
      chk("lb_byte",  {30'd0, byte_w}, 32'd3);
      chk("lb_ldsel", {29'd0, load_sel_w}, 32'd2);

      // SH into the upper halfword, then LH.
      op(1'b1, 32'h0000_0022, 32'h0000_BEEF, 2'b10, 1'b0, 3'b000);
      op(1'b1, 32'h0000_0022, 32'h0, 2'b00, 1'b1, 3'b100);
      chk("lh_rdata", rdata_w, 32'hBEEF_5678);
      chk("lh_byte",  {30'd0, byte_w}, 32'd2);

      // Misaligned SW is suppressed.
      op(1'b1, 32'h0000_0021, 32'hFFFF_FFFF, 2'b01, 1'b0, 3'b000);
      chk("missw_err", {31'd0, addr_err_w}, 32'd1);
      op(1'b1, 32'h0000_0020, 32'h0, 2'b00, 1'b1, 3'b000);
      chk("missw_rdata", rdata_w, 32'hBEEF_5678);
      chk("missw_err_clr", {31'd0, addr_err_w}, 32'd0);

      // Out-of-range SH: no write (word 0 must stay clear, no index wrap).
      op(1'b1, 32'h0000_1000, 32'h0000_1111, 2'b10, 1'b0, 3'b000);
      chk("oor_sh_err", {31'd0, addr_err_w}, 32'd1);
      op(1'b1, 32'h0000_0000, 32'h0, 2'b00, 1'b1, 3'b000);
      chk("oor_sh_nowrap", rdata_w, 32'h0000_0000);

      // Misaligned LHU: data still loaded, error flagged.
      op(1'b1, 32'h0000_0021, 32'h0, 2'b00, 1'b1, 3'b011);
      chk("mislhu_err",   {31'd0, addr_err_w}, 32'd1);
      chk("mislhu_rdata", rdata_w, 32'hBEEF_5678);
      chk("mislhu_ldsel", {29'd0, load_sel_w}, 32'd3);

      // Out-of-range LW reads zero with error.
      op(1'b1, 32'h0000_2000, 32'h0, 2'b00, 1'b1, 3'b000);
      chk("oor_lw_rdata", rdata_w, 32'h0000_0000);
      chk("oor_lw_err",   {31'd0, addr_err_w}, 32'd1);

      // Bubble carrying a store: no write, valid_w=0, no error even if bad.
      op(1'b0, 32'h0000_0021, 32'hDEAD_BEEF, 2'b01, 1'b0, 3'b000);
      chk("bub_valid", {31'd0, valid_w}, 32'd0);
      chk("bub_err",   {31'd0, addr_err_w}, 32'd0);
      op(1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 2'b01, 1'b0, 3'b000);
      op(1'b1, 32'h0000_0020, 32'h0, 2'b00, 1'b1, 3'b000);
      chk("bub_nowrite", rdata_w, 32'hBEEF_5678);

      // Read-before-write on the same edge.
      op(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 2'b01, 1'b0, 3'b000);
      op(1'b1, 32'h0000_0040, 32'h5555_AAAA, 2'b01, 1'b1, 3'b000);
      chk("rbw_old", rdata_w, 32'hCAFE_F00D);
      op(1'b1, 32'h0000_0040, 32'h0, 2'b00, 1'b1, 3'b000);
      chk("rbw_new", rdata_w, 32'h5555_AAAA);

      // SB into lane 0 of 0x40.
      op(1'b1, 32'h0000_0040, 32'h0000_0077, 2'b11, 1'b0, 3'b000);
      op(1'b1, 32'h0000_0040, 32'h0, 2'b00, 1'b1, 3'b001);
      chk("sb0_rdata", rdata_w, 32'h5555_AA77);

      // Reset between two stores; the second store coincides with reset.
      op(1'b1, 32'h0000_0060, 32'h0000_0077, 2'b01, 1'b0, 3'b000);
      m_valid = 1'b1; addr = 32'h0000_0064; wdata = 32'h0000_0088;
      store_sel = 2'b01; load_en = 1'b0; load_sel = 3'b000;
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_reset_outs("mid_rst");
      rst_n = 1'b1;
      op(1'b1, 32'h0000_0020, 32'h0, 2'b00, 1'b1, 3'b000);
      chk("mid_rst_20", rdata_w, 32'h0000_0000);
      op(1'b1, 32'h0000_0040, 32'h0, 2'b00, 1'b1, 3'b000);
      chk("mid_rst_40", rdata_w, 32'h0000_0000);
      op(1'b1, 32'h0000_0060, 32'h0, 2'b00, 1'b1, 3'b000);
      chk("mid_rst_60", rdata_w, 32'h0000_0000);
      op(1'b1, 32'h0000_0064, 32'h0, 2'b00, 1'b1, 3'b000);
      chk("mid_rst_64", rdata_w, 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
